capture_reader: RTL and testbench



---
 rtl/capture_reader_pkg.sv | 16 +
 rtl/capture_reader_rd_skid_fifo.sv | 64 ++++++
 rtl/capture_reader.sv | 134 +++++++++++++
 tb/tb_capture_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_reader_pkg.sv
// Shared watcher definitions: readout state encoding and the default
// buffer geometry used by both the trigger node and the capture reader.
package capture_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Sample width equals the trigger node's detector count.
    localparam int DEFAULT_DATA_W = 3;
    localparam int DEFAULT_DEPTH  = 5461;
    localparam int DEFAULT_ADDR_W = 16;

endpackage

// File: rtl/capture_reader_rd_skid_fifo.sv
// Two-entry FIFO that absorbs RAM read data so the output stream can stall
// without losing samples already requested from the RAM.
module rd_skid_fifo #(
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop;

    // Next-state computation for storage, pointers and occupancy.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != 2'd0);
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            // NOTE: the two storage entries are reset because the head entry drives out_data directly.
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);

    // The reader's credit rule must keep data from arriving into a full FIFO.
    no_push_when_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/capture_reader.sv
// Capture buffer readout engine: once capture has stopped, streams the
// sample RAM out oldest-first over a valid/ready interface.
module capture_reader
    import capture_reader_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              cfg_clk,
    input  logic              cfg_rst,
    input  logic              start,
    input  logic              stop_flag,
    input  logic              overflow_flag,
    input  logic [ADDR_W-1:0] stop_addr,
    output logic              rd_ce,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // One extra bit so a total of 2^ADDR_W samples is representable.
    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  consume_cnt_q, consume_cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;

    logic fifo_full, fifo_empty;
    logic pop, credit_ok, issue;

    rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk     (cfg_clk),
        .rst     (cfg_rst),
        .push    (inflight_q),
        .wr_data (rd_data),
        .pop     (pop),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Stream handshake and read-credit decision: at most two samples may be
    // in flight or buffered; a pop in this cycle frees one slot immediately.
    always_comb begin
        pop       = !fifo_empty && out_ready;
        credit_ok = pop || (!fifo_full && !(inflight_q && !fifo_empty));
        issue     = (state_q == RUN) && (issue_cnt_q != total_q) && credit_ok;
        out_last  = !fifo_empty && ((consume_cnt_q + CNT_W'(1)) == total_q);
    end

    // Next-state logic: range latch, modulo-DEPTH address walk, completion.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        issue_cnt_d   = issue_cnt_q;
        consume_cnt_d = pop ? consume_cnt_q + CNT_W'(1) : consume_cnt_q;
        total_d       = total_q;
        inflight_d    = issue;
        done_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && stop_flag) begin
                    state_d       = RUN;
                    issue_cnt_d   = '0;
                    consume_cnt_d = '0;
                    if (overflow_flag) begin
                        // Oldest sample sits just past the last write.
                        total_d = DEPTH_CNT;
                        addr_d  = (stop_addr == LAST_ADDR) ? '0 : stop_addr + ADDR_W'(1);
                    end else begin
                        total_d = {1'b0, stop_addr} + CNT_W'(1);
                        addr_d  = '0;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if ((issue_cnt_q + CNT_W'(1)) == total_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset drops any read still in flight.
    always_ff @(posedge cfg_clk) begin
        if (cfg_rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            issue_cnt_q   <= '0;
            consume_cnt_q <= '0;
            total_q       <= '0;
            inflight_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            issue_cnt_q   <= issue_cnt_d;
            consume_cnt_q <= consume_cnt_d;
            total_q       <= total_d;
            inflight_q    <= inflight_d;
            done_q        <= done_d;
        end
    end

    assign rd_ce     = issue;
    assign rd_addr   = addr_q;
    assign out_valid = !fifo_empty;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_capture_reader.sv
// Directed bench for capture_reader. Instance a uses DEPTH=16/ADDR_W=4 so
// a full buffer needs the extra counter bit; instance b uses DEPTH=8 for
// the wrap cases. Each RAM is modelled as a registered read of pat(addr).
module tb_capture_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic       stop_flag, overflow_flag, out_ready;
    logic [3:0] stop_addr_a;
    logic [2:0] stop_addr_b;

    logic       rd_ce_a, out_valid_a, out_last_a, busy_a, done_a;
    logic [3:0] rd_addr_a;
    logic [2:0] rd_data_a, out_data_a;
    logic       rd_ce_b, out_valid_b, out_last_b, busy_b, done_b;
    logic [2:0] rd_addr_b;
    logic [2:0] rd_data_b, out_data_b;

    int vectors    = 0;
    int miscompares = 0;

    logic       sel;
    logic       cur_rd_ce, cur_valid, cur_last, cur_busy, cur_done;
    logic [3:0] cur_rd_addr;
    logic [2:0] cur_data;

    logic [3:0] got_addr[$];
    logic [2:0] got_data[$];
    logic       got_last[$];
    int         first_valid, done_cyc, done_pulses, max_out, unstable;
    logic       busy_c1, busy_at_done, timed_out;

    capture_reader #(.DATA_W(3), .DEPTH(16), .ADDR_W(4)) dut_a (
        .cfg_clk(clk), .cfg_rst(rst), .start(start_a), .stop_flag(stop_flag),
        .overflow_flag(overflow_flag), .stop_addr(stop_addr_a), .rd_ce(rd_ce_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_last(out_last_a),
        .busy(busy_a), .done(done_a)
    );

    capture_reader #(.DATA_W(3), .DEPTH(8), .ADDR_W(3)) dut_b (
        .cfg_clk(clk), .cfg_rst(rst), .start(start_b), .stop_flag(stop_flag),
        .overflow_flag(overflow_flag), .stop_addr(stop_addr_b), .rd_ce(rd_ce_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_last(out_last_b),
        .busy(busy_b), .done(done_b)
    );

    initial forever #5 clk = ~clk;

    // Sample content stored at each address (distinct over any 8 addresses).
    function automatic logic [2:0] pat(input int a);
        return 3'((a * 5 + 3) % 8);
    endfunction

    always @(posedge clk) begin
        if (rd_ce_a) rd_data_a <= pat(int'(rd_addr_a));
        if (rd_ce_b) rd_data_b <= pat(int'(rd_addr_b));
    end

    always_comb begin
        if (sel) begin
            cur_rd_ce = rd_ce_b; cur_rd_addr = {1'b0, rd_addr_b}; cur_data = out_data_b;
            cur_valid = out_valid_b; cur_last = out_last_b; cur_busy = busy_b; cur_done = done_b;
        end else begin
            cur_rd_ce = rd_ce_a; cur_rd_addr = rd_addr_a; cur_data = out_data_a;
            cur_valid = out_valid_a; cur_last = out_last_a; cur_busy = busy_a; cur_done = done_a;
        end
    end

    // Drives one readout (start in cycle 0) and records what the DUT did.
    // Called and returns at posedge+2; cycle k is sampled at posedge+2.
    task automatic run_readout(input logic s, input int saddr, input logic ovf,
                               input int ready_pct, input int restart_at, input int max_cycles);
        int   issued, accepted;
        logic prev_stall;
        logic [2:0] prev_data;
        logic prev_last;
        got_addr.delete(); got_data.delete(); got_last.delete();
        first_valid = -1; done_cyc = -1; done_pulses = 0; max_out = 0; unstable = 0;
        busy_c1 = 1'b0; busy_at_done = 1'b1; timed_out = 1'b0;
        issued = 0; accepted = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        sel = s; stop_flag = 1'b1; overflow_flag = ovf; out_ready = 1'b0;
        stop_addr_a = 4'(saddr); stop_addr_b = 3'(saddr);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        for (int k = 1; k <= max_cycles; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            if (k == restart_at) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
                stop_addr_a = 4'd3; stop_addr_b = 3'd3; overflow_flag = ~ovf;
            end
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (cur_rd_ce) begin got_addr.push_back(cur_rd_addr); issued++; end
            if (prev_stall && (!cur_valid || cur_data !== prev_data || cur_last !== prev_last)) unstable++;
            if (cur_valid && first_valid < 0) first_valid = k;
            if (k == 1) busy_c1 = cur_busy;
            if (cur_done) begin
                done_pulses++;
                if (done_cyc < 0) begin done_cyc = k; busy_at_done = cur_busy; end
            end
            if (cur_valid && out_ready) begin
                got_data.push_back(cur_data); got_last.push_back(cur_last); accepted++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            prev_stall = cur_valid && !out_ready;
            prev_data  = cur_data;
            prev_last  = cur_last;
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        if (done_cyc < 0) timed_out = 1'b1;
        start_a = 1'b0; start_b = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] va;
        logic [10:0] vb;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        vectors++; if (rd_ce_a !== 1'b0) begin miscompares++; $display("FAIL reset_rd_ce: got %b, expected 0", rd_ce_a); end
        vectors++; if (rd_addr_a !== 4'd0) begin miscompares++; $display("FAIL reset_rd_addr: got %0d, expected 0", rd_addr_a); end
        vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid_a); end
        vectors++; if (out_last_a !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b, expected 0", out_last_a); end
        vectors++; if (out_data_a !== 3'd0) begin miscompares++; $display("FAIL reset_out_data: got %0d, expected 0", out_data_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", done_a); end
        vb = {rd_ce_b, rd_addr_b, out_valid_b, out_last_b, out_data_b, busy_b, done_b};
        vectors++; if (vb !== 11'd0) begin miscompares++; $display("FAIL reset_outputs_b: got %h, expected 0", vb); end
        rst = 1'b0;
        @(posedge clk); #2;
        va = {rd_ce_a, rd_addr_a, out_valid_a, out_last_a, out_data_a, busy_a, done_a};
        vectors++; if (va !== 12'd0) begin miscompares++; $display("FAIL idle_after_reset: got %h, expected 0", va); end
    endtask

    // Full-rate readout scenario; expected range and done cycle are hand-computed.
    task automatic test_readout(input string name, input logic s, input int saddr, input logic ovf,
                                input int exp_first, input int exp_total, input int depth, input int exp_done);
        run_readout(s, saddr, ovf, 100, 0, 60);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL %s timeout: got no done, expected done", name); end
        vectors++; if (got_addr.size() != exp_total) begin miscompares++; $display("FAIL %s read_count: got %0d, expected %0d", name, got_addr.size(), exp_total); end
        vectors++; if (got_data.size() != exp_total) begin miscompares++; $display("FAIL %s sample_count: got %0d, expected %0d", name, got_data.size(), exp_total); end
        for (int i = 0; i < got_addr.size() && i < exp_total; i++) begin
            vectors++;
            if (got_addr[i] !== 4'((exp_first + i) % depth)) begin
                miscompares++; $display("FAIL %s rd_addr[%0d]: got %0d, expected %0d", name, i, got_addr[i], (exp_first + i) % depth);
            end
        end
        for (int i = 0; i < got_data.size() && i < exp_total; i++) begin
            vectors++;
            if (got_data[i] !== pat((exp_first + i) % depth) || got_last[i] !== (i == exp_total - 1)) begin
                miscompares++; $display("FAIL %s sample[%0d]: got data %0d last %b, expected data %0d last %b",
                                        name, i, got_data[i], got_last[i], pat((exp_first + i) % depth), i == exp_total - 1);
            end
        end
        vectors++; if (first_valid != 3) begin miscompares++; $display("FAIL %s first_valid_cycle: got %0d, expected 3", name, first_valid); end
        vectors++; if (done_cyc != exp_done) begin miscompares++; $display("FAIL %s done_cycle: got %0d, expected %0d", name, done_cyc, exp_done); end
        vectors++; if (done_pulses != 1) begin miscompares++; $display("FAIL %s done_pulses: got %0d, expected 1", name, done_pulses); end
        vectors++; if (busy_c1 !== 1'b1) begin miscompares++; $display("FAIL %s busy_cycle1: got %b, expected 1", name, busy_c1); end
        vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL %s busy_at_done: got %b, expected 0", name, busy_at_done); end
    endtask

    task automatic test_backpressure();
        run_readout(1'b0, 12, 1'b1, 30, 0, 600);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL bp timeout: got no done, expected done"); end
        vectors++; if (got_data.size() != 16) begin miscompares++; $display("FAIL bp sample_count: got %0d, expected 16", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            vectors++;
            if (got_data[i] !== pat((13 + i) % 16) || got_last[i] !== (i == 15)) begin
                miscompares++; $display("FAIL bp sample[%0d]: got data %0d last %b, expected data %0d last %b",
                                        i, got_data[i], got_last[i], pat((13 + i) % 16), i == 15);
            end
        end
        vectors++; if (unstable != 0) begin miscompares++; $display("FAIL bp stall_stability: got %0d changes, expected 0", unstable); end
        vectors++; if (max_out > 2) begin miscompares++; $display("FAIL bp outstanding: got %0d, expected at most 2", max_out); end
        vectors++; if (done_pulses != 1) begin miscompares++; $display("FAIL bp done_pulses: got %0d, expected 1", done_pulses); end
    endtask

    task automatic test_ignored_start();
        int seen = 0;
        sel = 1'b0; stop_flag = 1'b0; overflow_flag = 1'b0; stop_addr_a = 4'd9;
        start_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1; start_a = 1'b0; #1;
            if (busy_a || rd_ce_a) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL ignored_start_no_stop: got %0d active cycles, expected 0", seen); end
        // Second start at cycle 4 also changes stop_addr/overflow; both must be ignored.
        run_readout(1'b0, 9, 1'b0, 100, 4, 60);
        vectors++; if (got_addr.size() != 10) begin miscompares++; $display("FAIL restart read_count: got %0d, expected 10", got_addr.size()); end
        for (int i = 0; i < got_addr.size() && i < 10; i++) begin
            vectors++;
            if (got_addr[i] !== 4'(i)) begin miscompares++; $display("FAIL restart rd_addr[%0d]: got %0d, expected %0d", i, got_addr[i], i); end
        end
        vectors++; if (got_data.size() != 10 || got_last[got_last.size()-1] !== 1'b1) begin
            miscompares++; $display("FAIL restart samples: got %0d samples, expected 10 ending with last", got_data.size());
        end
        vectors++; if (done_cyc != 13 || done_pulses != 1) begin miscompares++; $display("FAIL restart done: got cycle %0d pulses %0d, expected cycle 13 pulses 1", done_cyc, done_pulses); end
    endtask

    task automatic test_reset_mid_run();
        int accepted = 0;
        int k = 0;
        int bad = 0;
        logic [11:0] va;
        sel = 1'b0; stop_flag = 1'b1; overflow_flag = 1'b0; stop_addr_a = 4'd9;
        start_a = 1'b1;
        while (accepted < 3 && k < 20) begin
            @(posedge clk); #1; start_a = 1'b0; out_ready = 1'b1; #1;
            if (out_valid_a) accepted++;
            k++;
        end
        vectors++; if (accepted < 3) begin miscompares++; $display("FAIL midrst accepted: got %0d, expected 3", accepted); end
        rst = 1'b1;
        @(posedge clk); #2;
        va = {rd_ce_a, rd_addr_a, out_valid_a, out_last_a, out_data_a, busy_a, done_a};
        vectors++; if (va !== 12'd0) begin miscompares++; $display("FAIL midrst outputs: got %h, expected 0", va); end
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #2;
            if (done_a || out_valid_a || busy_a) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL midrst quiet: got %0d active cycles, expected 0", bad); end
        out_ready = 1'b0;
        run_readout(1'b0, 9, 1'b0, 100, 0, 60);
        vectors++; if (got_addr.size() == 0 || got_addr[0] !== 4'd0) begin miscompares++; $display("FAIL midrst restart_addr: got %0d reads, expected first address 0", got_addr.size()); end
        vectors++; if (got_data.size() != 10 || done_cyc != 13) begin miscompares++; $display("FAIL midrst rerun: got %0d samples done %0d, expected 10 done 13", got_data.size(), done_cyc); end
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; stop_flag = 1'b0; overflow_flag = 1'b0;
        stop_addr_a = '0; stop_addr_b = '0; out_ready = 1'b0; sel = 1'b0;
        test_reset();
        test_readout("non_overflow", 1'b0, 9, 1'b0, 0, 10, 16, 13);
        test_readout("overflow_wrap", 1'b1, 5, 1'b1, 6, 8, 8, 11);
        test_readout("stop_at_end", 1'b1, 7, 1'b1, 0, 8, 8, 11);
        test_readout("full_counter", 1'b0, 15, 1'b1, 0, 16, 16, 19);
        test_readout("single", 1'b0, 0, 1'b0, 0, 1, 16, 4);
        test_backpressure();
        test_ignored_start();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
